// File: rtl/sysid_reader.sv
// sysid_reader: reads the system ID (word 0) and build timestamp (word 1) over Avalon-MM
// and compares both against the values this build was generated with.
`default_nettype none

module sysid_reader #(
    parameter logic [31:0] EXPECTED_ID    = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS    = 32'd1646633220,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout,
    output logic [31:0] captured_id,
    output logic [31:0] captured_ts
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ID_REQ  = 3'd1,
        ID_WAIT = 3'd2,
        TS_REQ  = 3'd3,
        TS_WAIT = 3'd4,
        FINISH  = 3'd5
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] cnt;
    logic        accept;
    logic        resp;
    logic        expired;

    assign accept  = avm_read && !avm_waitrequest;
    // A beat only counts while waiting, or in the very cycle the request is accepted.
    assign resp    = avm_readdatavalid &&
                     ((state == ID_WAIT) || (state == TS_WAIT) ||
                      (((state == ID_REQ) || (state == TS_REQ)) && accept));
    assign expired = (cnt == CNT_LAST);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            cnt         <= 16'd0;
            avm_address <= 1'b0;
            avm_read    <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            id_ok       <= 1'b0;
            ts_ok       <= 1'b0;
            timeout     <= 1'b0;
            captured_id <= 32'd0;
            captured_ts <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    state       <= ID_REQ;
                    busy        <= 1'b1;
                    avm_read    <= 1'b1;
                    avm_address <= 1'b0;
                    cnt         <= 16'd0;
                end
                ID_REQ, ID_WAIT: begin
                    if (resp) begin
                        captured_id <= avm_readdata;
                        state       <= TS_REQ;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b1;
                        cnt         <= 16'd0;
                    end else if (expired) begin
                        state       <= FINISH;
                        timeout     <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (accept) begin
                            avm_read <= 1'b0;
                            state    <= ID_WAIT;
                        end
                    end
                end
                TS_REQ, TS_WAIT: begin
                    if (resp) begin
                        captured_ts <= avm_readdata;
                        state       <= FINISH;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        id_ok       <= (captured_id == EXPECTED_ID);
                        ts_ok       <= (avm_readdata == EXPECTED_TS);
                    end else if (expired) begin
                        state       <= FINISH;
                        timeout     <= 1'b1;
                        done        <= 1'b1;
                        busy        <= 1'b0;
                        avm_read    <= 1'b0;
                        avm_address <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                    end else begin
                        cnt <= cnt + 16'd1;
                        if (accept) begin
                            avm_read <= 1'b0;
                            state    <= TS_WAIT;
                        end
                    end
                end
                FINISH: begin
                    if (start) begin
                        state       <= ID_REQ;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        captured_id <= 32'd0;
                        captured_ts <= 32'd0;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        cnt         <= 16'd0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    busy     <= 1'b0;
                    avm_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sysid_reader.sv
// tb_sysid_reader: directed bench with a small configurable Avalon-MM slave model.
`default_nettype none

module tb_sysid_reader;

    localparam logic [31:0] TS_VAL = 32'd1646633220;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        avm_address;
    logic        avm_read;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] avm_readdata = 32'd0;
    logic        avm_readdatavalid = 1'b0;
    logic        busy, done, id_ok, ts_ok, timeout;
    logic [31:0] captured_id, captured_ts;

    int checks = 0;
    int failures = 0;

    // slave configuration, written only by the stimulus process
    int          stall_cfg = 0;
    int          lat_cfg = 1;
    logic        resp_en = 1'b1;
    logic [31:0] data0 = 32'd0;
    logic [31:0] data1 = TS_VAL;

    // slave/monitor state, written only by the slave process
    int          stall_cnt = 0;
    int          pend_cnt = 0;
    logic [31:0] pend_data = 32'd0;
    logic        last_stalled = 1'b0;
    logic        last_addr = 1'b0;
    int          addr_err = 0;
    int          addr1_reads = 0;

    sysid_reader #(
        .EXPECTED_ID   (32'h0000_0000),
        .EXPECTED_TS   (TS_VAL),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .start            (start),
        .avm_address      (avm_address),
        .avm_read         (avm_read),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .busy             (busy),
        .done             (done),
        .id_ok            (id_ok),
        .ts_ok            (ts_ok),
        .timeout          (timeout),
        .captured_id      (captured_id),
        .captured_ts      (captured_ts)
    );

    always #5 clock = ~clock;

    // Slave responds half a cycle after the DUT updates its request.
    always @(negedge clock) begin
        if (!reset_n) begin
            stall_cnt         = 0;
            pend_cnt          = 0;
            last_stalled      = 1'b0;
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = 1'b0;
        end else begin
            if (last_stalled && avm_read && (avm_address != last_addr))
                addr_err = addr_err + 1;
            if (avm_read && avm_address)
                addr1_reads = addr1_reads + 1;
            avm_readdatavalid = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt = pend_cnt - 1;
                if (pend_cnt == 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata      = pend_data;
                end
            end
            if (avm_read) begin
                if (stall_cnt < stall_cfg) begin
                    avm_waitrequest = 1'b1;
                    stall_cnt       = stall_cnt + 1;
                end else begin
                    avm_waitrequest = 1'b0;
                    stall_cnt       = 0;
                    if (resp_en) begin
                        if (lat_cfg == 0) begin
                            avm_readdatavalid = 1'b1;
                            avm_readdata      = avm_address ? data1 : data0;
                        end else begin
                            pend_cnt  = lat_cfg;
                            pend_data = avm_address ? data1 : data0;
                        end
                    end
                end
            end else begin
                avm_waitrequest = 1'b0;
                stall_cnt       = 0;
            end
            last_stalled = avm_read && avm_waitrequest;
            last_addr    = avm_address;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks = checks + 1;
        if (got !== exp) begin
            failures = failures + 1;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 40 && !done; i++) tick(1);
        check(tag, {31'd0, done}, 32'd1);
    endtask

    int base_a1;
    int base_err;

    initial begin
        // reset state
        tick(2);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_read", {31'd0, avm_read}, 32'd0);
        check("rst_capid", captured_id, 32'd0);

        // zero-wait slave, one-cycle latency: done on the 5th edge after release
        reset_n = 1'b1;
        tick(1);
        check("auto_read", {31'd0, avm_read}, 32'd1);
        check("auto_busy", {31'd0, busy}, 32'd1);
        tick(3);
        check("zw_notdone", {31'd0, done}, 32'd0);
        tick(1);
        check("zw_done", {31'd0, done}, 32'd1);
        check("zw_idok", {31'd0, id_ok}, 32'd1);
        check("zw_tsok", {31'd0, ts_ok}, 32'd1);
        check("zw_tmo", {31'd0, timeout}, 32'd0);
        check("zw_busy", {31'd0, busy}, 32'd0);
        check("zw_capts", captured_ts, TS_VAL);

        // zero-latency slave: response in the accept cycle skips the wait states
        lat_cfg = 0;
        pulse_start();
        check("zl_read", {31'd0, avm_read}, 32'd1);
        check("zl_clr", {31'd0, done}, 32'd0);
        tick(1);
        check("zl_tsreq", {31'd0, avm_address}, 32'd1);
        tick(1);
        check("zl_done", {31'd0, done}, 32'd1);
        check("zl_ok", {30'd0, id_ok, ts_ok}, 32'd3);

        // three stall cycles per read, wrong ID
        lat_cfg   = 1;
        stall_cfg = 3;
        data0     = 32'h0000_1234;
        base_err  = addr_err;
        pulse_start();
        tick(2);
        check("st_hold", {30'd0, avm_read, avm_address}, 32'd2);
        wait_done("st_wait");
        check("st_capid", captured_id, 32'h0000_1234);
        check("st_idok", {31'd0, id_ok}, 32'd0);
        check("st_tsok", {31'd0, ts_ok}, 32'd1);
        check("st_addr", addr_err - base_err, 32'd0);

        // silent slave: timeout exactly 8 cycles after ID_REQ entry
        stall_cfg = 0;
        resp_en   = 1'b0;
        base_a1   = addr1_reads;
        pulse_start();
        tick(7);
        check("to_early", {31'd0, timeout}, 32'd0);
        check("to_busy", {31'd0, busy}, 32'd1);
        tick(1);
        check("to_flag", {31'd0, timeout}, 32'd1);
        check("to_done", {31'd0, done}, 32'd1);
        check("to_ok", {30'd0, id_ok, ts_ok}, 32'd0);
        tick(2);
        check("to_noaddr1", addr1_reads - base_a1, 32'd0);

        // start during ID_WAIT ignored, start in FINISH restarts
        resp_en = 1'b1;
        data0   = 32'hAAAA_5555;
        pulse_start();
        tick(1);
        check("ig_wait", {30'd0, avm_read, busy}, 32'd1);
        pulse_start();
        check("ig_busy", {31'd0, busy}, 32'd1);
        tick(2);
        check("ig_done", {31'd0, done}, 32'd1);
        check("ig_capid", captured_id, 32'hAAAA_5555);
        check("ig_ok", {30'd0, id_ok, ts_ok}, 32'd1);
        tick(2);
        check("ig_hold", {30'd0, done, avm_read}, 32'd2);
        pulse_start();
        check("rs_clr", {29'd0, done, id_ok, ts_ok}, 32'd0);
        check("rs_capid", captured_id, 32'd0);
        check("rs_req", {30'd0, avm_read, avm_address}, 32'd2);
        wait_done("rs_wait");

        // async reset mid TS_WAIT, then a clean sequence
        lat_cfg = 3;
        data0   = 32'd0;
        pulse_start();
        tick(5);
        check("ar_tswait", {30'd0, avm_read, busy}, 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("ar_read", {31'd0, avm_read}, 32'd0);
        check("ar_outs", {28'd0, busy, done, id_ok, ts_ok}, 32'd0);
        check("ar_capid", captured_id, 32'd0);
        @(posedge clock);
        #1 reset_n = 1'b1;
        wait_done("ar_wait");
        check("ar_ok", {29'd0, id_ok, ts_ok, timeout}, 32'd6);
        check("ar_capts", captured_ts, TS_VAL);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/sysid_reader.md
SYSID_READER -- requirements
Module: sysid_reader

Interface
REQ-001 Parameter: EXPECTED_ID, default 32'h0000_0000, system ID value the design expects at word address 0.
REQ-002 Parameter: EXPECTED_TS, default 32'd1646633220, build timestamp the design expects at word address 1.
REQ-003 Parameter: TIMEOUT_CYCLES, default 255, maximum cycles allowed per read transaction; legal range 1..65535.
REQ-004 Port: clock  input  1  single clock; all logic is rising-edge.
REQ-005 Port: reset_n  input  1  asynchronous, active-low reset.
REQ-006 Port: start  input  1  single-cycle request to re-run the check sequence.
REQ-007 Port: avm_address  output  1  Avalon-MM master word address to the sysid slave.
REQ-008 Port: avm_read  output  1  Avalon-MM read strobe.
REQ-009 Port: avm_waitrequest  input  1  slave stall; a read is accepted on a cycle with avm_read=1 and avm_waitrequest=0.
REQ-010 Port: avm_readdata  input  32  slave read data.
REQ-011 Port: avm_readdatavalid  input  1  avm_readdata is valid this cycle.
REQ-012 Port: busy  output  1  sequence in progress.
REQ-013 Port: done  output  1  sequence finished; holds until the next start.
REQ-014 Port: id_ok  output  1  captured ID equals EXPECTED_ID.
REQ-015 Port: ts_ok  output  1  captured timestamp equals EXPECTED_TS.
REQ-016 Port: timeout  output  1  a read exceeded TIMEOUT_CYCLES.
REQ-017 Port: captured_id  output  32  data returned from address 0.
REQ-018 Port: captured_ts  output  32  data returned from address 1.

Function
REQ-019 The FSM SHALL have the states IDLE, ID_REQ, ID_WAIT, TS_REQ, TS_WAIT and FINISH.
REQ-020 On the first clock after reset deassertion, IDLE SHALL advance to ID_REQ unconditionally (auto-start once).
REQ-021 In ID_REQ, avm_read=1 and avm_address=0 SHALL be held until accepted, then the FSM moves to ID_WAIT.
REQ-022 In ID_WAIT, avm_read=0; on avm_readdatavalid=1, captured_id SHALL load avm_readdata and the FSM moves to TS_REQ.
REQ-023 TS_REQ/TS_WAIT SHALL mirror ID_REQ/ID_WAIT with avm_address=1 and capture into captured_ts, then go to FINISH.
REQ-024 A valid beat arriving in the same cycle as acceptance SHALL be taken as that read's response (zero-latency slave supported), skipping the WAIT state.
REQ-025 avm_readdatavalid outside ID_WAIT/TS_WAIT (or the REQ acceptance cycle) SHALL be ignored.
REQ-026 A per-read 16-bit counter SHALL clear on entry to each REQ state and increment every cycle in REQ/WAIT; reaching TIMEOUT_CYCLES without a response SHALL set timeout=1, abandon the sequence and go to FINISH.
REQ-027 In FINISH: done=1, busy=0; id_ok = (captured_id==EXPECTED_ID) && !timeout; ts_ok = (captured_ts==EXPECTED_TS) && !timeout; flags registered on entry.
REQ-028 busy SHALL be 1 in every state other than IDLE and FINISH.
REQ-029 start=1 in FINISH SHALL clear done, id_ok, ts_ok, timeout, captured_id, captured_ts and enter ID_REQ the next cycle.
REQ-030 start asserted while busy SHALL be ignored (not queued).
REQ-031 Comparisons SHALL be full 32-bit, unsigned, exact equality.

Reset
REQ-032 reset_n=0 SHALL immediately force state IDLE and all outputs and counters to 0, including avm_read, mid-transaction.
REQ-033 A response arriving after reset deassertion for a read issued before reset SHALL be ignored.

Verification
REQ-034 Zero-wait slave (waitrequest=0, readdatavalid 1 cycle after accept, data 0 / 1646633220) -> done=1, id_ok=1, ts_ok=1, timeout=0 within 6 cycles of reset release.
REQ-035 waitrequest held 3 cycles per read, data 32'h1234 at addr 0 -> avm_address stable while stalled; id_ok=0, ts_ok=1, captured_id=32'h1234.
REQ-036 TIMEOUT_CYCLES=8, slave never asserts readdatavalid -> timeout=1 exactly 8 cycles after ID_REQ entry, done=1, id_ok=ts_ok=0, no address-1 read issued.
REQ-037 start pulsed during ID_WAIT, then again in FINISH -> first ignored; second clears flags and issues a new address-0 read next cycle.
REQ-038 reset_n pulsed low during TS_WAIT -> avm_read=0 and all outputs 0 immediately; fresh sequence completes correctly after release.
